// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced push-button conditioner with press/release strobes and auto-repeat
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clock,
    input  logic areset_n,
    input  logic key_n,
    input  logic enable_repeat,
    output logic key_level,
    output logic key_pulse,
    output logic release_pulse,
    output logic repeat_active
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    // The debounce counter only ever counts 0 .. DEBOUNCE_CYCLES-1
    localparam int DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE     = DEB_W'(1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_SAT    = '1;

    typedef enum logic [1:0] {
        ST_UP       = 2'd0,
        ST_DEB_DOWN = 2'd1,
        ST_DOWN     = 2'd2,
        ST_DEB_UP   = 2'd3
    } state_t;

    logic              sync1_q, sync2_q;
    state_t            state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              key_pulse_q, key_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              repeat_active_q, repeat_active_d;
    logic              key_s;
    logic              held;

    // Two-flop synchronizer for the asynchronous button; resets to "released"
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = ~sync2_q;

    // State, counters and registered strobes
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q         <= ST_UP;
            deb_cnt_q       <= '0;
            hold_cnt_q      <= '0;
            key_pulse_q     <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            deb_cnt_q       <= deb_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            key_pulse_q     <= key_pulse_d;
            release_pulse_q <= release_pulse_d;
            repeat_active_q <= repeat_active_d;
        end
    end

    // Debounce FSM plus hold/auto-repeat timing; an accepted release wins over a repeat event
    always_comb begin
        state_d         = state_q;
        deb_cnt_d       = deb_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        key_pulse_d     = 1'b0;
        release_pulse_d = 1'b0;
        repeat_active_d = repeat_active_q;
        held            = 1'b0;

        case (state_q)
            ST_UP: begin
                deb_cnt_d = '0;
                if (key_s) begin
                    state_d = ST_DEB_DOWN;
                end
            end
            ST_DEB_DOWN: begin
                if (!key_s) begin
                    state_d   = ST_UP;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d         = ST_DOWN;
                    deb_cnt_d       = '0;
                    key_pulse_d     = 1'b1;
                    hold_cnt_d      = '0;
                    repeat_active_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            ST_DOWN: begin
                held = 1'b1;
                if (!key_s) begin
                    state_d   = ST_DEB_UP;
                    deb_cnt_d = '0;
                end
            end
            ST_DEB_UP: begin
                if (key_s) begin
                    state_d   = ST_DOWN;
                    deb_cnt_d = '0;
                    held      = 1'b1;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d         = ST_UP;
                    deb_cnt_d       = '0;
                    release_pulse_d = 1'b1;
                    repeat_active_d = 1'b0;
                    hold_cnt_d      = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                    held      = 1'b1;
                end
            end
            default: begin
                state_d   = ST_UP;
                deb_cnt_d = '0;
            end
        endcase

        if (held) begin
            if (!enable_repeat) begin
                hold_cnt_d      = '0;
                repeat_active_d = 1'b0;
            end else if ((!repeat_active_q && hold_cnt_q == DELAY_LAST) ||
                         ( repeat_active_q && hold_cnt_q == PERIOD_LAST)) begin
                key_pulse_d     = 1'b1;
                repeat_active_d = 1'b1;
                hold_cnt_d      = '0;
            end else if (hold_cnt_q != HOLD_SAT) begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
        end
    end

    assign key_level     = (state_q == ST_DOWN) || (state_q == ST_DEB_UP);
    assign key_pulse     = key_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_active = repeat_active_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed scoreboard bench for key_conditioner
module tb_key_conditioner;

    localparam int BIG = 1000000;

    logic clock = 1'b0;
    logic areset_n = 1'b0;
    logic key_n = 1'b1;
    logic enable_repeat = 1'b0;
    logic key_level, key_pulse, release_pulse, repeat_active;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int kp_q[$];
    int rp_q[$];
    int lvl_on = BIG, lvl_off = BIG, ra_on = BIG, ra_off = BIG;
    int t0, r0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clock(clock),
        .areset_n(areset_n),
        .key_n(key_n),
        .enable_repeat(enable_repeat),
        .key_level(key_level),
        .key_pulse(key_pulse),
        .release_pulse(release_pulse),
        .repeat_active(repeat_active)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One rising edge; outputs sampled on the following falling edge against the scoreboard
    task automatic step();
        int e;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        check("key_level", 32'(key_level), 32'(cyc >= lvl_on && cyc < lvl_off));
        check("repeat_active", 32'(repeat_active), 32'(cyc >= ra_on && cyc < ra_off));
        if (key_pulse === 1'b1) begin
            e = (kp_q.size() > 0) ? kp_q.pop_front() : -1;
            check("key_pulse_cycle", cyc, e);
        end
        if (release_pulse === 1'b1) begin
            e = (rp_q.size() > 0) ? rp_q.pop_front() : -1;
            check("release_pulse_cycle", cyc, e);
        end
        if (key_pulse === 1'b1 || release_pulse === 1'b1) begin
            check("pulse_exclusive", 32'(key_pulse & release_pulse), 0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic end_scenario(input string tag);
        check({tag, "_kp_pending"}, kp_q.size(), 0);
        check({tag, "_rp_pending"}, rp_q.size(), 0);
        kp_q.delete();
        rp_q.delete();
    endtask

    initial begin
        // reset state
        run(3);
        check("rst_key_level", 32'(key_level), 0);
        check("rst_key_pulse", 32'(key_pulse), 0);
        check("rst_release_pulse", 32'(release_pulse), 0);
        check("rst_repeat_active", 32'(repeat_active), 0);
        areset_n = 1'b1;
        run(4);

        // A: plain press held 40 cycles, no repeat, then clean release
        enable_repeat = 1'b0;
        key_n = 1'b0;
        t0 = cyc + 1;
        kp_q.push_back(t0 + 6);
        lvl_on = t0 + 6; lvl_off = BIG;
        run(40);
        key_n = 1'b1;
        r0 = cyc + 1;
        rp_q.push_back(r0 + 6);
        lvl_off = r0 + 6;
        run(12);
        end_scenario("A");

        // B: bouncing every 2 cycles must produce nothing
        for (int i = 0; i < 15; i++) begin
            key_n = ~key_n;
            run(2);
        end
        key_n = 1'b1;
        run(10);
        end_scenario("B");

        // C: auto-repeat cadence with a short release glitch during hold
        enable_repeat = 1'b1;
        key_n = 1'b0;
        t0 = cyc + 1;
        kp_q.push_back(t0 + 6);
        kp_q.push_back(t0 + 26);
        kp_q.push_back(t0 + 34);
        kp_q.push_back(t0 + 42);
        kp_q.push_back(t0 + 50);
        kp_q.push_back(t0 + 58);
        lvl_on = t0 + 6; lvl_off = BIG;
        ra_on = t0 + 26; ra_off = BIG;
        run(37);
        key_n = 1'b1;
        run(2);
        key_n = 1'b0;
        run(20);
        key_n = 1'b1;
        r0 = cyc + 1;
        rp_q.push_back(r0 + 6);
        lvl_off = r0 + 6; ra_off = r0 + 6;
        run(12);
        end_scenario("C");

        // D: enable_repeat dropped mid-repeat, then re-armed while held
        key_n = 1'b0;
        t0 = cyc + 1;
        kp_q.push_back(t0 + 6);
        kp_q.push_back(t0 + 26);
        lvl_on = t0 + 6; lvl_off = BIG;
        ra_on = t0 + 26; ra_off = BIG;
        run(31);
        enable_repeat = 1'b0;
        ra_off = t0 + 31;
        run(5);
        enable_repeat = 1'b1;
        ra_on = t0 + 55; ra_off = BIG;
        kp_q.push_back(t0 + 55);
        kp_q.push_back(t0 + 63);
        run(25);
        key_n = 1'b1;
        r0 = cyc + 1;
        rp_q.push_back(r0 + 6);
        lvl_off = r0 + 6; ra_off = r0 + 6;
        run(12);
        end_scenario("D");

        // E: reset during hold aborts silently; re-acceptance needs full debounce
        key_n = 1'b0;
        t0 = cyc + 1;
        kp_q.push_back(t0 + 6);
        kp_q.push_back(t0 + 26);
        lvl_on = t0 + 6; lvl_off = BIG;
        ra_on = t0 + 26; ra_off = BIG;
        run(30);
        lvl_off = t0 + 30; ra_off = t0 + 30;
        areset_n = 1'b0;
        run(1);
        check("midrst_key_pulse", 32'(key_pulse), 0);
        check("midrst_release_pulse", 32'(release_pulse), 0);
        run(2);
        areset_n = 1'b1;
        lvl_on = t0 + 39; lvl_off = BIG;
        ra_on = t0 + 59; ra_off = BIG;
        kp_q.push_back(t0 + 39);
        run(18);
        key_n = 1'b1;
        r0 = cyc + 1;
        rp_q.push_back(r0 + 6);
        lvl_off = r0 + 6; ra_on = BIG;
        run(12);
        end_scenario("E");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
